// File: rtl/sync_ram_arbiter.sv
// Round-robin arbiter sharing one registered-read, byte-strobed synchronous RAM
// between NUM_REQ valid/ready requesters, with response hold under back-pressure.
module sync_ram_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 13
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic [NUM_REQ*32-1:0]     i_req_addr,
  input  logic [NUM_REQ*4-1:0]      i_req_wstrb,
  input  logic [NUM_REQ*32-1:0]     i_req_wdata,
  output logic [NUM_REQ-1:0]        o_resp_valid,
  input  logic [NUM_REQ-1:0]        i_resp_ready,
  output logic [31:0]               o_resp_rdata,
  output logic [ADDR_WIDTH-1:0]     o_ram_raddr,
  output logic [ADDR_WIDTH-1:0]     o_ram_waddr,
  output logic [3:0]                o_ram_wstrb,
  output logic [31:0]               o_ram_wdata,
  input  logic [31:0]               i_ram_rdata
);

  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDW-1:0]        r_owner;
  logic                  r_is_rd;
  logic                  r_first;
  logic [IDW-1:0]        r_rr_last;
  logic [31:0]           r_hold;

  logic                  w_found;
  logic [IDW-1:0]        w_win;
  logic [ADDR_WIDTH-1:0] w_word;
  logic [3:0]            w_strb;
  logic [31:0]           w_wdata;
  logic                  w_owner_rdy;
  logic                  w_grant_en;
  logic                  w_grant;
  logic [31:0]           w_first_data;
  logic                  w_unused_addr_bits;

  assign w_unused_addr_bits = ^i_req_addr;

  // Round-robin search: indices above r_rr_last first, then wrap to the rest.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_word  = '0;
    w_strb  = '0;
    w_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req_valid[i] && (IDW'(i) > r_rr_last)) begin
        w_found = 1'b1;
        w_win   = IDW'(i);
        w_word  = i_req_addr[32*i+2 +: ADDR_WIDTH];
        w_strb  = i_req_wstrb[4*i +: 4];
        w_wdata = i_req_wdata[32*i +: 32];
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req_valid[i] && (IDW'(i) <= r_rr_last)) begin
        w_found = 1'b1;
        w_win   = IDW'(i);
        w_word  = i_req_addr[32*i+2 +: ADDR_WIDTH];
        w_strb  = i_req_wstrb[4*i +: 4];
        w_wdata = i_req_wdata[32*i +: 32];
      end
    end
  end

  // Reset gates the grant so no RAM write can leave while reset is asserted.
  assign w_owner_rdy = i_resp_ready[r_owner];
  assign w_grant_en  = i_rst_n && ((r_state == ST_IDLE) || w_owner_rdy);
  assign w_grant     = w_grant_en && w_found;

  assign o_req_ready = w_grant ? (NUM_REQ'(1) << w_win) : '0;
  assign o_ram_raddr = (i_rst_n && w_found) ? w_word : '0;
  assign o_ram_waddr = (i_rst_n && w_found) ? w_word : '0;
  assign o_ram_wstrb = w_grant ? w_strb : 4'h0;
  assign o_ram_wdata = (w_grant && (w_strb != 4'h0)) ? w_wdata : 32'h0;

  assign w_first_data = r_is_rd ? i_ram_rdata : 32'h0;
  assign o_resp_valid = (r_state == ST_RESP) ? (NUM_REQ'(1) << r_owner) : '0;
  assign o_resp_rdata = (r_state != ST_RESP) ? 32'h0 :
                        r_first              ? w_first_data : r_hold;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_grant) w_state_nxt = ST_RESP;
      ST_RESP: if (w_owner_rdy && !w_grant) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Ownership, round-robin pointer and first-cycle read data capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner   <= '0;
      r_is_rd   <= 1'b0;
      r_first   <= 1'b0;
      r_rr_last <= IDW'(NUM_REQ - 1);
      r_hold    <= '0;
    end else begin
      r_first <= w_grant;
      if (w_grant) begin
        r_owner   <= w_win;
        r_is_rd   <= (w_strb == 4'h0);
        r_rr_last <= w_win;
      end
      if ((r_state == ST_RESP) && r_first) begin
        r_hold <= w_first_data;
      end
    end
  end

endmodule

// File: tb/tb_sync_ram_arbiter.sv
// Scoreboard bench for sync_ram_arbiter: driver pushes expected responses on
// grant, a negedge monitor pops and compares on each response handshake.
module tb_sync_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_addr;
  logic [7:0]  req_wstrb;
  logic [63:0] req_wdata;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_rdata;
  logic [12:0] ram_raddr;
  logic [12:0] ram_waddr;
  logic [3:0]  ram_wstrb;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          gcyc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem [0:8191];

  sync_ram_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(13)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_addr(req_addr), .i_req_wstrb(req_wstrb), .i_req_wdata(req_wdata),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_rdata(resp_rdata),
    .o_ram_raddr(ram_raddr), .o_ram_waddr(ram_waddr), .o_ram_wstrb(ram_wstrb),
    .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-strobed RAM with registered read
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_wstrb[b]) mem[ram_waddr][8*b +: 8] <= ram_wdata[8*b +: 8];
    ram_rdata <= mem[ram_raddr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int id, input logic [31:0] data, input int lat);
    exp_t e;
    e.id = id; e.data = data; e.gcyc = cyc; e.lat = lat;
    sb.push_back(e);
  endtask

  // Response monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (resp_valid[i] && resp_ready[i]) begin
          if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL sb_underflow: response on req %0d with empty queue", i);
          end else begin
            e = sb.pop_front();
            check("resp_id", 32'(i), 32'(e.id));
            check("resp_data", resp_rdata, e.data);
            check("resp_lat", 32'(cyc - e.gcyc), 32'(e.lat));
          end
        end
      end
    end
  end

  // Single request on requester r; pushes the expected response when granted.
  task automatic drive(input int r, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wd, input logic [31:0] exp);
    logic got;
    got = 1'b0;
    req_valid[r]         = 1'b1;
    req_addr[32*r +: 32] = addr;
    req_wstrb[4*r +: 4]  = strb;
    req_wdata[32*r +: 32] = wd;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        got = 1'b1;
        push(r, exp, 1);
      end
      @(posedge clk); #1;
    end
    check("grant_seen", 32'(got), 32'd1);
    req_valid[r] = 1'b0;
    req_wstrb[4*r +: 4] = 4'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    rst_n = 1'b0;
    resp_ready = 2'b11;
    req_valid = 2'b01; req_addr = '0; req_wstrb = 8'h0f; req_wdata = {32'h0, 32'h11111111};

    // 1: reset state, with a write pending at the input
    repeat (10) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_ram_wstrb", 32'(ram_wstrb), 32'h0);
    check("rst_ram_raddr", 32'(ram_raddr), 32'h0);
    check("rst_ram_waddr", 32'(ram_waddr), 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    req_valid = 2'b00; req_wstrb = 8'h00;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_req_ready", 32'(req_ready), 32'h0);
    check("idle_ram_wstrb", 32'(ram_wstrb), 32'h0);
    @(posedge clk); #1;

    // 2: full write then read-back
    drive(0, 32'h0, 4'hf, 32'hdeadbeef, 32'h0);
    drive(0, 32'h0, 4'h0, 32'h0, 32'hdeadbeef);
    repeat (2) @(posedge clk); #1;

    // 3: partial writes, read-after-write on the last one
    drive(0, 32'h4,  4'h3, 32'hdeadbeef, 32'h0);
    drive(0, 32'h8,  4'hc, 32'hdeadbeef, 32'h0);
    drive(0, 32'h12, 4'h2, 32'hdeadbeef, 32'h0);
    drive(0, 32'h12, 4'h0, 32'h0, 32'h0000be00);
    drive(0, 32'h4,  4'h0, 32'h0, 32'h0000beef);
    drive(0, 32'h8,  4'h0, 32'h0, 32'hdead0000);
    repeat (2) @(posedge clk); #1;

    // 4: requester 1 alone, then both contending every cycle
    drive(1, 32'h8, 4'h0, 32'h0, 32'hdead0000);
    req_addr = {32'h4, 32'h0}; req_wstrb = 8'h00; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr_grant", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (req_ready == 2'b01) push(0, 32'hdeadbeef, 1);
      else if (req_ready == 2'b10) push(1, 32'h0000beef, 1);
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    repeat (2) @(posedge clk); #1;

    // 5: stalled read response held while req0 waits
    resp_ready = 2'b01;
    req_valid = 2'b10; req_addr = {32'h0, 32'h4};
    @(negedge clk);
    check("stall_grant1", 32'(req_ready), 32'h2);
    if (req_ready == 2'b10) push(1, 32'hdeadbeef, 4);
    @(posedge clk); #1;
    req_valid = 2'b01;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall_req_ready", 32'(req_ready), 32'h0);
      check("stall_resp_valid", 32'(resp_valid), 32'h2);
      check("stall_hold", resp_rdata, 32'hdeadbeef);
      @(posedge clk); #1;
    end
    resp_ready = 2'b11;
    @(negedge clk);
    check("release_grant0", 32'(req_ready), 32'h1);
    if (req_ready == 2'b01) push(0, 32'h0000beef, 1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (2) @(posedge clk); #1;

    // 6: reset during a stalled read with a write waiting
    resp_ready = 2'b10;
    req_valid = 2'b01; req_addr = {32'h4, 32'h0}; req_wstrb = 8'h00;
    @(negedge clk);
    check("r6_grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_wstrb = 8'h0f; req_wdata = {32'h0, 32'h12345678};
    @(negedge clk);
    check("r6_stall_valid", 32'(resp_valid), 32'h1);
    check("r6_stall_wstrb", 32'(ram_wstrb), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("r6_async_valid", 32'(resp_valid), 32'h0);
    check("r6_async_ready", 32'(req_ready), 32'h0);
    check("r6_async_wstrb", 32'(ram_wstrb), 32'h0);
    check("r6_async_rdata", resp_rdata, 32'h0);
    repeat (2) @(posedge clk); #1;
    req_valid = 2'b00; req_wstrb = 8'h00;
    rst_n = 1'b1;
    resp_ready = 2'b11;
    req_valid = 2'b11; req_addr = {32'h4, 32'h0};
    @(negedge clk);
    check("r6_first_winner", 32'(req_ready), 32'h1);
    if (req_ready == 2'b01) push(0, 32'hdeadbeef, 1);
    @(posedge clk); #1;
    req_valid = 2'b10;
    @(negedge clk);
    check("r6_second_winner", 32'(req_ready), 32'h2);
    if (req_ready == 2'b10) push(1, 32'h0000beef, 1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (3) @(posedge clk); #1;

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
